// File: rtl/sel_mux_pipe_pkg.sv
// sel_mux_pipe_pkg: shared types and constants for the sel_mux_pipe block.
//   STATE_W : width of the skid-buffer state register
//   state_e : skid-buffer occupancy states
//     ST_EMPTY - nothing held
//     ST_ONE   - main register M holds a word
//     ST_FULL  - M and skid register S both hold words
package sel_mux_pipe_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/sel_mux_core.sv
// sel_mux_core: purely combinational NUM_IN:1 word select.
// Ports:
//   in_x  [NUM_IN*WIDTH] flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel   [SEL_W]        channel index
//   out_x [WIDTH]        selected channel, all zeros when sel >= NUM_IN
module sel_mux_core
  import sel_mux_pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_x,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_x
);

  // Only indices 0..NUM_IN-1 ever match, so an out-of-range select
  // falls through to the zero default.
  always_comb begin
    out_x = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == k[SEL_W-1:0]) begin
        out_x = in_x[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: NUM_IN:1 select feeding a 2-entry skid buffer with a
// registered valid/ready output stage and synchronous flush.
//
// Handshake: a word moves across an interface on a rising edge where
// valid and ready are both high. A source that raises valid keeps valid
// and its data stable until that transfer happens. Ready never depends
// combinationally on valid. Here w_in_ready is a flop, and w_out_valid /
// w_out_x hold steady while stalled except when w_flush squashes them.
//
// Ports:
//   w_clk        clock, rising edge
//   w_rst_n      synchronous active-low reset
//   w_in_x       flattened input channels
//   w_sel_x      channel select, sampled with w_in_valid
//   w_in_valid   upstream offers a word
//   w_in_ready   block can accept (registered)
//   w_flush      squash every held word; the word offered this cycle is dropped
//   w_out_x      selected, registered word (main register M)
//   w_out_valid  w_out_x holds a word
//   w_out_ready  downstream accepts
//   w_err        sticky bad-select flag, only when SEL_MUX_PIPE_ERR_EN is defined
//
// Build option: define SEL_MUX_PIPE_ERR_EN to add the w_err port. It sets
// on any accepted word whose select is out of range and clears only on
// reset. Without it, out-of-range selects silently yield a zero word.
module sel_mux_pipe
  import sel_mux_pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    w_clk,
  input  logic                    w_rst_n,
  input  logic [NUM_IN*WIDTH-1:0] w_in_x,
  input  logic [SEL_W-1:0]        w_sel_x,
  input  logic                    w_in_valid,
  output logic                    w_in_ready,
  input  logic                    w_flush,
  output logic [WIDTH-1:0]        w_out_x,
  output logic                    w_out_valid,
  input  logic                    w_out_ready
`ifdef SEL_MUX_PIPE_ERR_EN
  ,
  output logic                    w_err
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sel_word;
  logic             in_fire;
  logic             out_fire;

  sel_mux_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_core (
    .in_x  (w_in_x),
    .sel   (w_sel_x),
    .out_x (sel_word)
  );

  // A word offered in a flush cycle is dropped, so flush gates in_fire.
  assign in_fire  = w_in_valid & in_ready_q & ~w_flush;
  assign out_fire = (state_q != ST_EMPTY) & w_out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          m_d     = sel_word;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_d = ST_FULL;
          s_d     = sel_word;
        end else if (in_fire && out_fire) begin
          m_d = sel_word;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready_q is low here, so only the drain side can move.
        if (out_fire) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (w_flush) begin
      state_d = ST_EMPTY;
    end
    // Ready is looked up from the next state so the flop is already
    // correct on the cycle the buffer fills or drains.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q    <= ST_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign w_in_ready  = in_ready_q;
  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_out_x     = m_q;

`ifdef SEL_MUX_PIPE_ERR_EN
  logic        err_q, err_d;
  logic [31:0] sel_ext;
  logic        sel_bad;

  assign sel_ext = 32'(w_sel_x);
  assign sel_bad = (sel_ext >= 32'(NUM_IN));

  // Flush does not clear the flag; only reset does.
  always_comb begin
    err_d = err_q | (in_fire & sel_bad);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign w_err = err_q;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: directed and randomised bench for sel_mux_pipe with
// WIDTH=8, NUM_IN=3 (so select value 3 is out of range).
module tb_sel_mux_pipe;

  localparam int W      = 8;
  localparam int NUM_IN = 3;
  localparam int SW     = $clog2(NUM_IN);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_IN*W-1:0] w_in_x;
  logic [SW-1:0]       w_sel_x;
  logic                w_in_valid;
  logic                w_in_ready;
  logic                w_flush;
  logic [W-1:0]        w_out_x;
  logic                w_out_valid;
  logic                w_out_ready;
`ifdef SEL_MUX_PIPE_ERR_EN
  logic                w_err;
`endif

  sel_mux_pipe #(
    .WIDTH  (W),
    .NUM_IN (NUM_IN)
  ) dut (
    .w_clk       (clk),
    .w_rst_n     (rst_n),
    .w_in_x      (w_in_x),
    .w_sel_x     (w_sel_x),
    .w_in_valid  (w_in_valid),
    .w_in_ready  (w_in_ready),
    .w_flush     (w_flush),
    .w_out_x     (w_out_x),
    .w_out_valid (w_out_valid),
    .w_out_ready (w_out_ready)
`ifdef SEL_MUX_PIPE_ERR_EN
    ,
    .w_err       (w_err)
`endif
  );

  // ---------------- counters / check helper ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A FIFO of at most two words; ready means the FIFO held fewer than two
  // words after the last edge.
  logic [W-1:0] exp_q[$];
  logic         m_ready = 1'b0;
  logic         m_err   = 1'b0;
  logic         m_zero  = 1'b1;  // no word stored since reset, out_x must read 0
  logic         started = 1'b0;

  function automatic logic [W-1:0] exp_word(input logic [NUM_IN*W-1:0] x, input logic [SW-1:0] s);
    if (int'(s) >= NUM_IN) return '0;
    return x[int'(s)*W +: W];
  endfunction

  always @(posedge clk) begin
    logic acc;
    started = 1'b1;
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_zero  = 1'b1;
    end else if (w_flush) begin
      exp_q.delete();
      m_ready = 1'b1;
    end else begin
      acc = w_in_valid && m_ready;
      if (exp_q.size() > 0 && w_out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(exp_word(w_in_x, w_sel_x));
        m_zero = 1'b0;
        if (int'(w_sel_x) >= NUM_IN) m_err = 1'b1;
      end
      m_ready = (exp_q.size() < 2);
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(w_out_valid), 32'(exp_q.size() > 0));
      check("in_ready", 32'(w_in_ready), 32'(m_ready));
      if (exp_q.size() > 0) check("out_x", 32'(w_out_x), 32'(exp_q[0]));
      else if (m_zero) check("out_x_zero", 32'(w_out_x), 32'd0);
`ifdef SEL_MUX_PIPE_ERR_EN
      check("err", 32'(w_err), 32'(m_err));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2);
    w_in_x = {c2, c1, c0};
  endtask

  task automatic offer(input logic [SW-1:0] s);
    w_in_valid = 1'b1;
    w_sel_x    = s;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    w_flush     = 1'b0;
    w_sel_x     = '0;
    set_ch(8'h11, 8'h22, 8'h33);

    // Reset state
    step();
    step();
    check("rst_valid", 32'(w_out_valid), 32'd0);
    check("rst_ready", 32'(w_in_ready), 32'd0);
    check("rst_out_x", 32'(w_out_x), 32'd0);
`ifdef SEL_MUX_PIPE_ERR_EN
    check("rst_err", 32'(w_err), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(w_in_ready), 32'd1);

    // Basic select: sel 2 then sel 0
    w_out_ready = 1'b1;
    offer(2'd2);
    step();
    check("basic_v0", 32'(w_out_valid), 32'd1);
    check("basic_x0", 32'(w_out_x), 32'h33);
    offer(2'd0);
    step();
    check("basic_v1", 32'(w_out_valid), 32'd1);
    check("basic_x1", 32'(w_out_x), 32'h11);
    w_in_valid = 1'b0;
    step();
    check("basic_drained", 32'(w_out_valid), 32'd0);

    // Back-pressure: A0..A3 on channel 0 with downstream stalled
    w_out_ready = 1'b0;
    set_ch(8'hA0, 8'h22, 8'h33);
    offer(2'd0);
    step();
    check("bp_x_a0", 32'(w_out_x), 32'hA0);
    check("bp_ready_one", 32'(w_in_ready), 32'd1);
    set_ch(8'hA1, 8'h22, 8'h33);
    step();
    check("bp_ready_full", 32'(w_in_ready), 32'd0);
    set_ch(8'hA2, 8'h22, 8'h33);
    step();
    check("bp_hold_x", 32'(w_out_x), 32'hA0);
    check("bp_hold_ready", 32'(w_in_ready), 32'd0);
    w_out_ready = 1'b1;
    step();
    check("bp_x_a1", 32'(w_out_x), 32'hA1);
    check("bp_recover_ready", 32'(w_in_ready), 32'd1);
    step();
    check("bp_x_a2", 32'(w_out_x), 32'hA2);
    set_ch(8'hA3, 8'h22, 8'h33);
    step();
    check("bp_x_a3", 32'(w_out_x), 32'hA3);
    check("bp_v_a3", 32'(w_out_valid), 32'd1);
    w_in_valid = 1'b0;
    step();
    check("bp_drained", 32'(w_out_valid), 32'd0);

    // Bad select: value 3 with three channels
    set_ch(8'h11, 8'h22, 8'h33);
    offer(2'd3);
    step();
    check("bad_v", 32'(w_out_valid), 32'd1);
    check("bad_x", 32'(w_out_x), 32'h00);
`ifdef SEL_MUX_PIPE_ERR_EN
    check("bad_err_set", 32'(w_err), 32'd1);
`endif
    offer(2'd1);
    step();
    check("good_after_bad_x", 32'(w_out_x), 32'h22);
`ifdef SEL_MUX_PIPE_ERR_EN
    check("err_sticky", 32'(w_err), 32'd1);
`endif
    w_in_valid = 1'b0;
    step();

    // Flush while FULL with a word offered
    w_out_ready = 1'b0;
    set_ch(8'h55, 8'h22, 8'h33);
    offer(2'd0);
    step();
    set_ch(8'h66, 8'h22, 8'h33);
    step();
    check("fl_full_ready", 32'(w_in_ready), 32'd0);
    set_ch(8'h77, 8'h22, 8'h33);
    w_flush = 1'b1;
    step();
    check("fl_valid", 32'(w_out_valid), 32'd0);
    check("fl_ready", 32'(w_in_ready), 32'd1);
    w_flush     = 1'b0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;
    step();
    check("fl_no_ghost", 32'(w_out_valid), 32'd0);
`ifdef SEL_MUX_PIPE_ERR_EN
    check("err_survives_flush", 32'(w_err), 32'd1);
`endif

    // Reset mid-operation from FULL
    w_out_ready = 1'b0;
    set_ch(8'h5A, 8'h22, 8'h33);
    offer(2'd0);
    step();
    set_ch(8'h5B, 8'h22, 8'h33);
    step();
    rst_n = 1'b0;
    step();
    check("mrst_valid", 32'(w_out_valid), 32'd0);
    check("mrst_ready", 32'(w_in_ready), 32'd0);
    check("mrst_x", 32'(w_out_x), 32'd0);
`ifdef SEL_MUX_PIPE_ERR_EN
    check("mrst_err", 32'(w_err), 32'd0);
`endif
    rst_n      = 1'b1;
    w_in_valid = 1'b0;
    step();
    check("mrst_ready_up", 32'(w_in_ready), 32'd1);
    check("mrst_no_stale", 32'(w_out_valid), 32'd0);

    // Randomised soak, checked every cycle by the scoreboard
    for (int i = 0; i < 10000; i++) begin
      set_ch(W'($urandom), W'($urandom), W'($urandom));
      w_sel_x     = SW'($urandom_range(0, 3));
      w_in_valid  = 1'($urandom_range(0, 1));
      w_out_ready = 1'($urandom_range(0, 3) != 0);
      w_flush     = ($urandom_range(0, 63) == 0);
      step();
    end

    // Drain
    w_in_valid  = 1'b0;
    w_flush     = 1'b0;
    w_out_ready = 1'b1;
    step();
    step();
    step();
    check("final_empty", 32'(w_out_valid), 32'd0);
    check("final_ready", 32'(w_in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
